// File: rtl/sst_stream_ctrl.sv
// -----------------------------------------------------------------------------
// sst_stream_ctrl
//
// Save-state initiator for one mapper slot. It drives the master side of the
// mapper save-state register bus. A save sweep reads registers 0..LAST_ADDR
// and streams each byte to the host. A load sweep takes host bytes and writes
// them back to the same addresses.
//
// Parameters
//   LAST_ADDR  final register address of a sweep (sweep covers 0..LAST_ADDR)
//   SETTLE     clocks sst_addr is held before sst_di is captured (1..15)
//   IDX_ADDR   address of the mapper index byte (optional feature only)
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   save_req, load_req, abort    sweep control (requests sampled in IDLE only)
//   busy, done, err              status: not idle / sweep-complete pulse /
//                                sticky index-mismatch flag
//   tx_data, tx_valid, tx_ready  save byte stream to the host
//   rx_data, rx_valid, rx_ready  load byte stream from the host
//   sst_act, sst_addr,           save-state register bus (master side)
//   sst_we_reg, sst_dato, sst_di
//   map_idx                      index of the currently active mapper
//
// Optional feature (macro SST_IDX_CHECK_EN): during a load the byte for
// IDX_ADDR is compared with map_idx instead of being written; a mismatch sets
// err. Without the macro err is tied low and IDX_ADDR is an ordinary address.
// -----------------------------------------------------------------------------
module sst_stream_ctrl #(
    parameter logic [7:0]  LAST_ADDR = 8'd127,
    parameter int unsigned SETTLE    = 1,
    parameter logic [7:0]  IDX_ADDR  = 8'd127
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       save_req,
    input  logic       load_req,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic       sst_act,
    output logic [7:0] sst_addr,
    output logic       sst_we_reg,
    output logic [7:0] sst_dato,
    input  logic [7:0] sst_di,
    input  logic [7:0] map_idx
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE);

    typedef enum logic [2:0] {
        IDLE,
        S_SET,
        S_SEND,
        L_RECV,
        L_WR,
        FIN
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] settle_cnt;
    logic       at_last;
    logic       settle_end;
    logic       idx_hit;

    // End of sweep is found by compare, so LAST_ADDR = 255 never relies on
    // the address counter overflowing.
    assign at_last    = (sst_addr == LAST_ADDR);
    // The counter is reloaded with SETTLE and the byte is captured in the
    // clock it steps from 1 to 0.
    assign settle_end = (settle_cnt == 4'd1);

`ifdef SST_IDX_CHECK_EN
    assign idx_hit = (sst_addr == IDX_ADDR);
`else
    assign idx_hit = 1'b0;
`endif

    // ---------------------------------------------------------------- state
    // NOTE: registers are updated with non-blocking assignments so that every
    // flop samples the values from before the edge, whatever the block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ----------------------------------------------------------- next state
    // NOTE: the default assignment at the top keeps this block free of
    // inferred latches when a branch does not assign state_nxt.
    always_comb begin
        state_nxt = state;
        if (state != IDLE && abort) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (save_req) begin
                        state_nxt = S_SET;
                    end else if (load_req) begin
                        state_nxt = L_RECV;
                    end
                end
                S_SET:  if (settle_end) state_nxt = S_SEND;
                S_SEND: if (tx_ready)   state_nxt = at_last ? FIN : S_SET;
                L_RECV: if (rx_valid)   state_nxt = L_WR;
                L_WR:   state_nxt = at_last ? FIN : L_RECV;
                FIN:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        busy       = (state != IDLE);
        done       = (state == FIN);
        tx_valid   = (state == S_SEND);
        rx_ready   = (state == L_RECV);
        // The bus is released in the FIN clock, together with done.
        sst_act    = (state != IDLE) && (state != FIN);
        // The index byte is checked instead of written when the check is on.
        sst_we_reg = (state == L_WR) && !idx_hit;
    end

    // ------------------------------------------------------------- datapath
    // Whenever the FSM heads for IDLE (sweep end, abort) the bus and stream
    // registers return to zero, so IDLE always looks like reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sst_addr   <= 8'd0;
            sst_dato   <= 8'd0;
            tx_data    <= 8'd0;
            settle_cnt <= 4'd0;
        end else if (state_nxt == IDLE) begin
            sst_addr   <= 8'd0;
            sst_dato   <= 8'd0;
            tx_data    <= 8'd0;
            settle_cnt <= 4'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    sst_addr   <= 8'd0;
                    settle_cnt <= SETTLE_LOAD;
                end
                S_SET: begin
                    settle_cnt <= settle_cnt - 4'd1;
                    if (settle_end) begin
                        tx_data <= sst_di;
                    end
                end
                S_SEND: begin
                    // tx_data is not touched here, so it stays stable while
                    // the host holds tx_ready low.
                    if (tx_ready && !at_last) begin
                        sst_addr   <= sst_addr + 8'd1;
                        settle_cnt <= SETTLE_LOAD;
                    end
                end
                L_RECV: begin
                    if (rx_valid) begin
                        sst_dato <= rx_data;
                    end
                end
                L_WR: begin
                    if (!at_last) begin
                        sst_addr <= sst_addr + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // --------------------------------------------------------- index check
`ifdef SST_IDX_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (state == IDLE && (save_req || load_req)) begin
            err <= 1'b0;
        end else if (state == L_WR && idx_hit && sst_dato != map_idx) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;

    logic unused_idx;
    assign unused_idx = ^{map_idx, IDX_ADDR};
`endif

endmodule

// File: tb/tb_sst_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sst_stream_ctrl
//
// Directed bench for sst_stream_ctrl with LAST_ADDR = 3, SETTLE = 1 and
// IDX_ADDR = 3. The mapper register file is modelled as sst_di = addr ^ 8'hA5.
// Expected tx bytes and register writes are built per sweep from the sweep
// rules into append-only queues. A per-cycle compare routine checks every
// handshake, strobe and status output against them.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sst_stream_ctrl;

    localparam logic [7:0] LAST    = 8'd3;
    localparam int         SETTLE  = 1;
    localparam logic [7:0] IDX     = 8'd3;
    localparam logic [7:0] MAP_IDX = 8'h99;
`ifdef SST_IDX_CHECK_EN
    localparam bit IDX_CHECK = 1'b1;
`else
    localparam bit IDX_CHECK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       save_req, load_req, abort;
    logic       busy, done, err;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ready;
    logic       sst_act, sst_we_reg;
    logic [7:0] sst_addr, sst_dato, sst_di, map_idx;

    assign sst_di  = sst_addr ^ 8'hA5;
    assign map_idx = MAP_IDX;

    always #5 clk = ~clk;

    sst_stream_ctrl #(
        .LAST_ADDR (LAST),
        .SETTLE    (SETTLE),
        .IDX_ADDR  (IDX)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .save_req   (save_req),
        .load_req   (load_req),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .sst_act    (sst_act),
        .sst_addr   (sst_addr),
        .sst_we_reg (sst_we_reg),
        .sst_dato   (sst_dato),
        .sst_di     (sst_di),
        .map_idx    (map_idx)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Model expectations: {addr, byte}, appended per sweep, consumed by index.
    logic [15:0] exp_tx[$];
    logic [15:0] exp_wr[$];
    int          tx_rd = 0;
    int          wr_rd = 0;

    // Observations.
    int tx_cyc[$];
    int wr_cyc[$];
    int done_cyc     = 0;
    int done_seen    = 0;
    int stall_seen   = 0;
    int rx_ready_cyc = 0;

    // Host-side stimulus state.
    logic [7:0] rx_q[$];
    logic       rx_en         = 1'b0;
    logic       rx_hs         = 1'b0;
    logic       tx_ready_base = 1'b0;
    logic [7:0] stall_addr    = 8'd0;
    int         stall_left    = 0;

    logic       prev_stall   = 1'b0;
    logic       prev_we      = 1'b0;
    logic       prev_done    = 1'b0;
    logic       prev_abort   = 1'b0;
    logic [7:0] prev_tx_data = 8'd0;
    logic [7:0] prev_addr    = 8'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison against the model, sampled on the falling edge.
    task automatic compare_cycle();
        if (prev_stall && !prev_abort) begin
            check("tx_hold_valid", 32'(tx_valid), 32'd1);
            check("tx_hold_data", 32'(tx_data), 32'(prev_tx_data));
            check("tx_hold_addr", 32'(sst_addr), 32'(prev_addr));
        end
        if (rx_hs) begin
            check("rx_ready_drop", 32'(rx_ready), 32'd0);
        end
        if (tx_valid && tx_ready) begin
            check("tx_byte_expected", 32'(tx_rd < exp_tx.size()), 32'd1);
            if (tx_rd < exp_tx.size()) begin
                check("tx_addr_data", 32'({sst_addr, tx_data}), 32'(exp_tx[tx_rd]));
                tx_rd++;
            end
            tx_cyc.push_back(cyc);
        end
        if (tx_valid && !tx_ready) stall_seen++;
        if (sst_we_reg) begin
            check("we_expected", 32'(wr_rd < exp_wr.size()), 32'd1);
            if (wr_rd < exp_wr.size()) begin
                check("we_addr_dato", 32'({sst_addr, sst_dato}), 32'(exp_wr[wr_rd]));
                wr_rd++;
            end
            check("we_single_clock", 32'(prev_we), 32'd0);
            wr_cyc.push_back(cyc);
        end
        if (rx_ready) rx_ready_cyc++;
        if (done) begin
            done_seen++;
            done_cyc = cyc;
            check("fin_act_low", 32'(sst_act), 32'd0);
            check("fin_busy", 32'(busy), 32'd1);
            check("done_single", 32'(prev_done), 32'd0);
        end
        if (!busy) begin
            check("idle_outputs",
                  32'({tx_valid, rx_ready, sst_act, sst_we_reg, done, sst_addr, sst_dato, tx_data}),
                  32'd0);
        end else if (!done) begin
            check("act_while_busy", 32'(sst_act), 32'd1);
        end
        prev_stall   = tx_valid && !tx_ready;
        prev_tx_data = tx_data;
        prev_addr    = sst_addr;
        rx_hs        = rx_valid && rx_ready;
        prev_we      = sst_we_reg;
        prev_done    = done;
        prev_abort   = abort;
    endtask

    // Host behaviour, applied just after each rising edge.
    task automatic drive_inputs();
        if (rx_hs && rx_q.size() > 0) void'(rx_q.pop_front());
        rx_valid = rx_en && (rx_q.size() > 0);
        rx_data  = rx_valid ? rx_q[0] : 8'h00;
        if (tx_valid && sst_addr == stall_addr && stall_left > 0) begin
            tx_ready = 1'b0;
            stall_left--;
        end else begin
            tx_ready = tx_ready_base;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (rst_n) compare_cycle();
        @(posedge clk);
        #1;
        cyc++;
        drive_inputs();
    endtask

    task automatic wait_done(input string name);
        int start;
        int n;
        start = done_seen;
        n = 0;
        while (done_seen == start && n < 200) begin
            tick();
            n++;
        end
        check(name, 32'(done_seen - start), 32'd1);
    endtask

    task automatic wait_writes(input int target);
        int n;
        n = 0;
        while (wr_cyc.size() < target && n < 200) begin
            tick();
            n++;
        end
        check("wait_writes", 32'(wr_cyc.size()), 32'(target));
    endtask

    // A save sweep streams every address 0..LAST with the mapper's byte.
    task automatic model_save();
        for (int a = 0; a <= int'(LAST); a++) begin
            exp_tx.push_back({8'(a), 8'(a) ^ 8'hA5});
        end
    endtask

    // A load sweep writes byte a to address a; with the index check on, the
    // index byte is compared instead of written. Only the first n_wr writes
    // are expected (sweeps cut short by abort/reset).
    task automatic model_load(input logic [31:0] bytes, input int n_wr, output logic exp_err);
        logic [7:0] b;
        exp_err = 1'b0;
        for (int a = 0; a <= int'(LAST); a++) begin
            b = bytes[31 - 8*a -: 8];
            rx_q.push_back(b);
            if (IDX_CHECK && 8'(a) == IDX) begin
                if (b != MAP_IDX) exp_err = 1'b1;
            end else if (a < n_wr) begin
                exp_wr.push_back({8'(a), b});
            end
        end
    endtask

    initial begin
        logic e_err;
        int   base_done, base_wr, base_rx, base_stall, base_exp;

        rst_n    = 1'b0;
        save_req = 1'b0;
        load_req = 1'b0;
        abort    = 1'b0;
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              32'({busy, done, err, tx_valid, rx_ready, sst_act, sst_we_reg, sst_addr, sst_dato, tx_data}),
              32'd0);
        rst_n = 1'b1;
        tx_ready_base = 1'b1;
        tick();

        // ---- save sweep, tx_ready tied high
        model_save();
        check("model_first_byte", 32'(exp_tx[0]), 32'h00A5);
        check("model_last_byte", 32'(exp_tx[3]), 32'h03A6);
        save_req = 1'b1;
        tick();
        save_req = 1'b0;
        check("save_start_busy", 32'(busy), 32'd1);
        check("save_start_act", 32'(sst_act), 32'd1);
        wait_done("save_done");
        check("save_all_bytes", 32'(tx_rd), 32'(exp_tx.size()));
        for (int i = 1; i < 4; i++) begin
            check("save_rate", 32'(tx_cyc[i] - tx_cyc[i-1]), 32'(SETTLE + 1));
        end
        check("save_done_after_last", 32'(done_cyc - tx_cyc[3]), 32'd1);
        tick();

        // ---- save sweep with byte 1 stalled for 5 clocks
        base_stall = stall_seen;
        stall_addr = 8'd1;
        stall_left = 5;
        model_save();
        save_req = 1'b1;
        tick();
        save_req = 1'b0;
        wait_done("stall_done");
        check("stall_cycles", 32'(stall_seen - base_stall), 32'd5);
        check("stall_all_bytes", 32'(tx_rd), 32'(exp_tx.size()));
        tick();

        // ---- load sweep 11,22,33,44 at full rate
        base_wr  = wr_cyc.size();
        base_exp = exp_wr.size();
        model_load(32'h11223344, 4, e_err);
        check("model_first_write", 32'(exp_wr[base_exp]), 32'h0011);
        check("model_third_write", 32'(exp_wr[base_exp + 2]), 32'h0233);
        rx_en = 1'b1;
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        wait_done("load_done");
        check("load_strobe_count", 32'(wr_cyc.size() - base_wr), 32'(exp_wr.size() - base_exp));
        check("load_all_writes", 32'(wr_rd), 32'(exp_wr.size()));
        check("load_rate_01", 32'(wr_cyc[base_wr + 1] - wr_cyc[base_wr]), 32'd2);
        check("load_rate_12", 32'(wr_cyc[base_wr + 2] - wr_cyc[base_wr + 1]), 32'd2);
        check("load_rx_consumed", 32'(rx_q.size()), 32'd0);
        check("load_err", 32'(err), 32'(e_err));
        rx_en = 1'b0;
        tick();

        // ---- abort a load after two bytes, then start a save
        base_done = done_seen;
        base_wr   = wr_cyc.size();
        model_load(32'h55667788, 2, e_err);
        rx_en = 1'b1;
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        wait_writes(base_wr + 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_idle_next", 32'(busy), 32'd0);
        repeat (4) tick();
        check("abort_two_strobes", 32'(wr_cyc.size() - base_wr), 32'd2);
        check("abort_no_done", 32'(done_seen - base_done), 32'd0);
        check("abort_writes", 32'(wr_rd), 32'(exp_wr.size()));
        rx_en = 1'b0;
        rx_q.delete();
        tick();
        model_save();
        save_req = 1'b1;
        tick();
        save_req = 1'b0;
        wait_done("save_after_abort");
        check("save_after_abort_bytes", 32'(tx_rd), 32'(exp_tx.size()));
        tick();

        // ---- simultaneous requests: save wins, later load_req ignored
        base_rx = rx_ready_cyc;
        base_wr = wr_cyc.size();
        model_save();
        rx_q.push_back(8'hEE);
        rx_en = 1'b1;
        save_req = 1'b1;
        load_req = 1'b1;
        tick();
        save_req = 1'b0;
        load_req = 1'b0;
        repeat (3) tick();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        wait_done("both_req_done");
        check("both_req_no_rx_ready", 32'(rx_ready_cyc - base_rx), 32'd0);
        check("both_req_no_strobe", 32'(wr_cyc.size() - base_wr), 32'd0);
        check("both_req_bytes", 32'(tx_rd), 32'(exp_tx.size()));
        rx_en = 1'b0;
        rx_q.delete();
        tick();

        // ---- asynchronous reset in the middle of a load
        base_wr = wr_cyc.size();
        model_load(32'hA1B2C3D4, 1, e_err);
        rx_en = 1'b1;
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        wait_writes(base_wr + 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_mid_outputs",
              32'({busy, sst_act, sst_we_reg, rx_ready, tx_valid, sst_addr, sst_dato}), 32'd0);
        rx_en = 1'b0;
        rx_q.delete();
        rx_hs      = 1'b0;
        prev_stall = 1'b0;
        prev_we    = 1'b0;
        prev_done  = 1'b0;
        prev_abort = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("reset_no_more_strobes", 32'(wr_cyc.size() - base_wr), 32'd1);
        check("reset_writes", 32'(wr_rd), 32'(exp_wr.size()));

        // ---- index byte mismatch, then match
        base_wr  = wr_cyc.size();
        base_exp = exp_wr.size();
        model_load(32'h1122339B, 4, e_err);
        check("model_idx_mismatch", 32'(e_err), 32'(IDX_CHECK));
        rx_en = 1'b1;
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        wait_done("idx_mismatch_done");
        check("idx_mismatch_err", 32'(err), 32'(e_err));
        check("idx_mismatch_strobes", 32'(wr_cyc.size() - base_wr), 32'(exp_wr.size() - base_exp));
        check("idx_mismatch_writes", 32'(wr_rd), 32'(exp_wr.size()));
        rx_en = 1'b0;
        tick();

        base_wr  = wr_cyc.size();
        base_exp = exp_wr.size();
        model_load(32'h11223399, 4, e_err);
        rx_en = 1'b1;
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        check("idx_err_cleared", 32'(err), 32'd0);
        wait_done("idx_match_done");
        check("idx_match_err", 32'(err), 32'(e_err));
        check("idx_match_strobes", 32'(wr_cyc.size() - base_wr), 32'(exp_wr.size() - base_exp));
        check("idx_match_writes", 32'(wr_rd), 32'(exp_wr.size()));
        rx_en = 1'b0;
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
